ttl_mux_arbiter: RTL and testbench
==================================

Name: ttl_mux_arbiter

Overview:
- Round-robin arbiter that shares one 74x153 dual 4-to-1 mux stage between four bus requesters.
- Drives the mux select pins (a, b) and the active-low strobe (both g pins tied together), and returns a one-hot grant to the requesters.
- Inserts a turnaround gap with the strobe high on every ownership change so the shared bus never glitches between sources.
- Sits between the requesting register-file and ALU sources and the 74x153 instances on the CPU data bus.

Parameters:
- MAX_BURST, 8: maximum consecutive GRANT cycles per ownership. 0 means unlimited. Legal range 0..255.
- TURN_CYCLES, 1: number of TURNAROUND cycles with the strobe high between grants. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request per source. Bit i selects mux input i. Level-sensitive; held high while the source wants the bus.
- sel_a  output  1  mux select LSB (datasheet pin a).
- sel_b  output  1  mux select MSB (datasheet pin b).
- enable_n  output  1  mux strobe, active low. Drives both g1 and g2.
- grant  output  4  one-hot grant. All zero when no source owns the bus.
- busy  output  1  high in GRANT or TURNAROUND.

Behaviour:
- All outputs are registered; there are no combinational paths from req to outputs.
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state=IDLE, enable_n=1, grant=0000, sel_b/sel_a=00, busy=0.
  - Rotating pointer ptr=3, so req[0] has highest priority first.
  - Burst and turnaround counters cleared.
- Arbitration:
  - Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). The first set req bit wins.
  - On a win, ptr is set to the winner.
- IDLE:
  - If any req bit is high at rising edge N, the state becomes GRANT after edge N.
  - From edge N: grant=onehot(w), {sel_b,sel_a}=w, enable_n=0, busy=1.
  - Latency from req to grant is one cycle.
- GRANT:
  - The burst counter increments every cycle.
  - Exit to TURNAROUND at the edge where req[owner]=0, or where the counter reaches MAX_BURST-1 (only when MAX_BURST≠0).
  - On exit: enable_n=1, grant=0000. Select pins hold their last value so the mux output does not change while undriven.
  - Requests from other sources during GRANT do not pre-empt the owner.
- TURNAROUND:
  - Lasts exactly TURN_CYCLES cycles.
  - On its final edge, arbitrate: if any req bit is high, go directly to GRANT with the new winner (same output timing as from IDLE); otherwise go to IDLE (busy=0).
  - Because ptr points at the previous owner, that owner has lowest priority and another active requester always wins. A lone requester is re-granted.
- Invariants:
  - enable_n=0 if and only if grant≠0000.
  - grant is never multi-hot.
  - {sel_b,sel_a} equals the index of the grant bit whenever grant≠0000.
  - grant never changes directly from one non-zero value to another; at least TURN_CYCLES zero cycles separate them.
- Width rules:
  - Burst counter is 8 bits and saturates at MAX_BURST-1.
  - Turnaround counter is 4 bits.
  - ptr is 2 bits with natural wrap (3+1 → 0).

Decomposition:
- Shared package ttl_bus_pkg holds:
  - state encoding: IDLE=2'd0, GRANT=2'd1, TURNAROUND=2'd2;
  - constant NUM_SRC=4;
  - the function onehot4(idx).
- One sub-module, rr_pick4: a combinational rotating-priority encoder. Inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and any_req. The FSM and counters stay in ttl_mux_arbiter.

Test Plan:
- Reset then req=0001 at cycle 2 → grant=0001, {b,a}=00, enable_n=0 from cycle 3; req drops at cycle 6 → enable_n=1, grant=0000 at cycle 7; IDLE with busy=0 at cycle 8.
- req=1111 held, MAX_BURST=8, TURN_CYCLES=1 → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles, separated by 1 cycle of grant=0000, enable_n=1. {b,a} tracks 00, 01, 10, 11.
- req=0100 only, held continuously → grant=0100 for 8 cycles, 1 turnaround cycle, then re-granted 0100 with {b,a}=10 unchanged through the gap.
- Owner 0 active while req[2] rises mid-burst → no pre-emption; after owner 0 releases and the turnaround completes, grant=0100. With req[0] re-asserted during the turnaround, grant is still 0100.
- MAX_BURST=0, req=0010 held for 300 cycles → grant stays 0010 for all 300 cycles with no turnaround.
- Assert reset asynchronously mid-grant, between clock edges → enable_n=1 and grant=0000 immediately. After release with req=1000, the first grant is 1000 and the next arbitration starts from ptr=3.

Source files
------------

// File: rtl/ttl_bus_pkg.sv
// ttl_bus_pkg: shared types and helpers for the 74x153 bus arbiter.
//   state_t  - arbiter FSM state encoding
//   NUM_SRC  - number of bus requesters (one per mux input)
//   onehot4  - converts a source index to a one-hot grant vector
package ttl_bus_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned TURN_W  = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    function automatic logic [NUM_SRC-1:0] onehot4(input logic [IDX_W-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational rotating-priority encoder.
//   req     - request vector, bit i = source i
//   ptr     - previous owner; search starts at ptr+1 and ends at ptr
//   winner  - index of the first set request in search order
//   any_req - at least one request is set
module rr_pick4
    import ttl_bus_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] w_idx;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        winner = '0;
        w_idx  = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            w_idx = ptr + IDX_W'(i);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/ttl_mux_arbiter.sv
// ttl_mux_arbiter: round-robin owner of a shared 74x153 dual 4:1 mux stage.
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset
//   req      - level requests, bit i selects mux input i
//   sel_a    - mux select LSB (pin a)
//   sel_b    - mux select MSB (pin b)
//   enable_n - active-low strobe to both g pins
//   grant    - one-hot grant, zero when nobody owns the bus
//   busy     - high in GRANT or TURNAROUND
module ttl_mux_arbiter
    import ttl_bus_pkg::*;
#(
    parameter int unsigned MAX_BURST   = 8,
    parameter int unsigned TURN_CYCLES = 1
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    output logic               sel_a,
    output logic               sel_b,
    output logic               enable_n,
    output logic [NUM_SRC-1:0] grant,
    output logic               busy
);

    // MAX_BURST = 0 means unlimited: the counter just parks at all-ones.
    localparam bit                 BURST_LIMITED = (MAX_BURST != 0);
    localparam logic [BURST_W-1:0] BURST_LAST    = (MAX_BURST == 0) ? '1 : BURST_W'(MAX_BURST - 1);
    localparam logic [TURN_W-1:0]  TURN_LAST     = TURN_W'(TURN_CYCLES - 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_sel;
    logic [BURST_W-1:0]   r_burst;
    logic [TURN_W-1:0]    r_turn;
    logic [NUM_SRC-1:0]   r_grant;
    logic                 r_enable_n;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic [IDX_W-1:0]     w_sel_nxt;
    logic [BURST_W-1:0]   w_burst_nxt;
    logic [TURN_W-1:0]    w_turn_nxt;
    logic [NUM_SRC-1:0]   w_grant_nxt;
    logic                 w_enable_n_nxt;
    logic                 w_busy_nxt;
    logic [IDX_W-1:0]     w_winner;
    logic                 w_any_req;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    // State, pointer, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= 2'd3;
            r_sel      <= '0;
            r_burst    <= '0;
            r_turn     <= '0;
            r_grant    <= '0;
            r_enable_n <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sel      <= w_sel_nxt;
            r_burst    <= w_burst_nxt;
            r_turn     <= w_turn_nxt;
            r_grant    <= w_grant_nxt;
            r_enable_n <= w_enable_n_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next state; the owner is always r_ptr while in GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_burst_nxt = r_burst;
        w_turn_nxt  = r_turn;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = GRANT;
                    w_ptr_nxt   = w_winner;
                    w_sel_nxt   = w_winner;
                    w_burst_nxt = '0;
                end
            end
            GRANT: begin
                w_burst_nxt = (r_burst == BURST_LAST) ? r_burst : r_burst + 8'd1;
                if (!req[r_ptr] || (BURST_LIMITED && (r_burst == BURST_LAST))) begin
                    w_state_nxt = TURNAROUND;
                    w_turn_nxt  = '0;
                end
            end
            TURNAROUND: begin
                if (r_turn == TURN_LAST) begin
                    if (w_any_req) begin
                        w_state_nxt = GRANT;
                        w_ptr_nxt   = w_winner;
                        w_sel_nxt   = w_winner;
                        w_burst_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_turn_nxt = r_turn + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode of the next state; select lines hold through gaps via r_sel.
    always_comb begin
        w_grant_nxt    = '0;
        w_enable_n_nxt = 1'b1;
        w_busy_nxt     = 1'b0;
        if (w_state_nxt == GRANT) begin
            w_grant_nxt    = onehot4(w_ptr_nxt);
            w_enable_n_nxt = 1'b0;
        end
        if (w_state_nxt != IDLE) begin
            w_busy_nxt = 1'b1;
        end
    end

    assign sel_a    = r_sel[0];
    assign sel_b    = r_sel[1];
    assign enable_n = r_enable_n;
    assign grant    = r_grant;
    assign busy     = r_busy;

endmodule

// File: tb/tb_ttl_mux_arbiter.sv
// tb_ttl_mux_arbiter: directed bench for ttl_mux_arbiter.
//   dut_a - MAX_BURST=8, TURN_CYCLES=1
//   dut_u - MAX_BURST=0 (unlimited burst), TURN_CYCLES=1
// Observed outputs are packed as {busy, enable_n, sel_b, sel_a, grant}.
module tb_ttl_mux_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_u;

    logic       a_sel_a, a_sel_b, a_enable_n, a_busy;
    logic [3:0] a_grant;
    logic       u_sel_a, u_sel_b, u_enable_n, u_busy;
    logic [3:0] u_grant;

    int n_run;
    int n_fail;

    logic [1:0] own;
    logic [3:0] g;

    ttl_mux_arbiter #(.MAX_BURST(8), .TURN_CYCLES(1)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .sel_a    (a_sel_a),
        .sel_b    (a_sel_b),
        .enable_n (a_enable_n),
        .grant    (a_grant),
        .busy     (a_busy)
    );

    ttl_mux_arbiter #(.MAX_BURST(0), .TURN_CYCLES(1)) dut_u (
        .clk      (clk),
        .reset    (reset),
        .req      (req_u),
        .sel_a    (u_sel_a),
        .sel_b    (u_sel_b),
        .enable_n (u_enable_n),
        .grant    (u_grant),
        .busy     (u_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bus_a();
        return {a_busy, a_enable_n, a_sel_b, a_sel_a, a_grant};
    endfunction

    function automatic logic [7:0] bus_u();
        return {u_busy, u_enable_n, u_sel_b, u_sel_a, u_grant};
    endfunction

    // Expected bus: strobe is low exactly when a grant is active.
    function automatic logic [7:0] ex(input logic [3:0] eg, input logic [1:0] es, input logic eb);
        return {eb, (eg == 4'b0000), es, eg};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        req_u  = 4'b0000;
        own    = 2'd0;
        g      = 4'b0000;

        // Reset state
        @(negedge clk);
        check("reset_a", bus_a(), ex(4'b0000, 2'd0, 1'b0));
        check("reset_u", bus_u(), ex(4'b0000, 2'd0, 1'b0));
        reset = 1'b0;

        // Single requester, one-cycle latency, release, idle
        req = 4'b0001;
        @(negedge clk);
        check("t1_first", bus_a(), ex(4'b0001, 2'd0, 1'b1));
        repeat (3) begin
            @(negedge clk);
            check("t1_hold", bus_a(), ex(4'b0001, 2'd0, 1'b1));
        end
        req = 4'b0000;
        @(negedge clk);
        check("t1_gap", bus_a(), ex(4'b0000, 2'd0, 1'b1));
        @(negedge clk);
        check("t1_idle", bus_a(), ex(4'b0000, 2'd0, 1'b0));

        // All requesting: 8-cycle bursts rotating 0,1,2,3,0 with one-cycle gaps
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            own = 2'(k % 4);
            g   = 4'b0001 << own;
            repeat (8) begin
                @(negedge clk);
                check("t2_grant", bus_a(), ex(g, own, 1'b1));
            end
            if (k < 4) begin
                @(negedge clk);
                check("t2_gap", bus_a(), ex(4'b0000, own, 1'b1));
            end
        end

        // Lone requester 2: capped burst, gap with select held, re-grant
        req = 4'b0100;
        @(negedge clk);
        check("t3_gap0", bus_a(), ex(4'b0000, 2'd0, 1'b1));
        repeat (8) begin
            @(negedge clk);
            check("t3_grant", bus_a(), ex(4'b0100, 2'd2, 1'b1));
        end
        @(negedge clk);
        check("t3_gap", bus_a(), ex(4'b0000, 2'd2, 1'b1));
        @(negedge clk);
        check("t3_regrant", bus_a(), ex(4'b0100, 2'd2, 1'b1));

        // No pre-emption; previous owner loses the next arbitration
        req = 4'b0000;
        @(negedge clk);
        check("t4_rel_gap", bus_a(), ex(4'b0000, 2'd2, 1'b1));
        @(negedge clk);
        check("t4_rel_idle", bus_a(), ex(4'b0000, 2'd2, 1'b0));
        req = 4'b0001;
        @(negedge clk);
        check("t4_own0", bus_a(), ex(4'b0001, 2'd0, 1'b1));
        req = 4'b0101;
        repeat (3) begin
            @(negedge clk);
            check("t4_nopreempt", bus_a(), ex(4'b0001, 2'd0, 1'b1));
        end
        req = 4'b0100;
        @(negedge clk);
        check("t4_gap", bus_a(), ex(4'b0000, 2'd0, 1'b1));
        req = 4'b0101;
        @(negedge clk);
        check("t4_winner2", bus_a(), ex(4'b0100, 2'd2, 1'b1));
        @(negedge clk);
        check("t4_hold2", bus_a(), ex(4'b0100, 2'd2, 1'b1));

        // Asynchronous reset mid-grant
        req = 4'b0000;
        @(negedge clk);
        check("t6_pre_gap", bus_a(), ex(4'b0000, 2'd2, 1'b1));
        @(negedge clk);
        check("t6_pre_idle", bus_a(), ex(4'b0000, 2'd2, 1'b0));
        req = 4'b0010;
        @(negedge clk);
        check("t6_grant1", bus_a(), ex(4'b0010, 2'd1, 1'b1));
        #2 reset = 1'b1;
        #1 check("t6_async", bus_a(), ex(4'b0000, 2'd0, 1'b0));
        req = 4'b1000;
        @(negedge clk);
        check("t6_held", bus_a(), ex(4'b0000, 2'd0, 1'b0));
        reset = 1'b0;
        @(negedge clk);
        check("t6_first", bus_a(), ex(4'b1000, 2'd3, 1'b1));
        req = 4'b1001;
        repeat (2) begin
            @(negedge clk);
            check("t6_own3", bus_a(), ex(4'b1000, 2'd3, 1'b1));
        end
        req = 4'b0001;
        @(negedge clk);
        check("t6_gap", bus_a(), ex(4'b0000, 2'd3, 1'b1));
        @(negedge clk);
        check("t6_next", bus_a(), ex(4'b0001, 2'd0, 1'b1));

        // Unlimited burst: no turnaround over 300 cycles
        req   = 4'b0000;
        req_u = 4'b0010;
        repeat (300) begin
            @(negedge clk);
            check("t5_unlimited", bus_u(), ex(4'b0010, 2'd1, 1'b1));
        end
        req_u = 4'b0000;
        @(negedge clk);
        check("t5_release", bus_u(), ex(4'b0000, 2'd1, 1'b1));
        @(negedge clk);
        check("t5_idle", bus_u(), ex(4'b0000, 2'd1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
